// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the security alarm controller blocks.
//   - Keypad special key codes (ENTER / CLEAR)
//   - Keypad controller state encoding (kp_state_t)
//   - Alarm FSM state encoding (alarm_state_t); the keypad's armed_in is
//     simply "alarm state != AL_OFF"
//   - is_digit(): true for key codes 0..9
// ---------------------------------------------------------------------------
package alarm_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hB;

   typedef enum logic [1:0] {
      KP_IDLE    = 2'd0,
      KP_ENTRY   = 2'd1,
      KP_CHECK   = 2'd2,
      KP_LOCKOUT = 2'd3
   } kp_state_t;

   typedef enum logic [1:0] {
      AL_OFF       = 2'd0,
      AL_ARMED     = 2'd1,
      AL_TRIGGERED = 2'd2,
      AL_ALARM_ON  = 2'd3
   } alarm_state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage

// File: rtl/alarm_timer.sv
// ---------------------------------------------------------------------------
// alarm_timer
// Loadable down-counter with a one-cycle registered expiry pulse.
// Loading value V at edge k makes expired high from edge k+V to edge k+V+1,
// so a consumer sampling expired acts at edge k+V+1. Loading 0 expires
// immediately after the load edge. A new load restarts the count and
// cancels any expiry that has not yet been reached.
// Ports:
//   clk     in  1 : clock
//   rst     in  1 : synchronous active-high reset
//   load    in  1 : load value into the counter
//   value   in  W : count to load
//   expired out 1 : one-cycle pulse when the count runs out
// ---------------------------------------------------------------------------
module alarm_timer #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] count;

   // The counter idles at zero. It fires expired on the 1 -> 0 step, or
   // straight away when it is loaded with zero, so every load produces
   // exactly one pulse unless it is reloaded first.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         expired <= 1'b0;
      end else if (load) begin
         count   <= value;
         expired <= (value == '0);
      end else if (count != '0) begin
         count   <= count - W'(1);
         expired <= (count == W'(1));
      end else begin
         expired <= 1'b0;
      end
   end

endmodule

// File: rtl/alarm_keypad_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_keypad_ctrl
// Keypad front end for the alarm controller. Collects up to four digits,
// checks them against PIN on ENTER, and issues single-cycle arm/disarm
// commands or an err pulse. Consecutive wrong entries lead to a timed
// lockout; an idle entry is abandoned after TIMEOUT_CYCLES.
// Ports:
//   clk        in  1 : clock
//   rst        in  1 : synchronous active-high reset
//   key_valid  in  1 : one-cycle keypress strobe
//   key_code   in  4 : 0-9 digit, A ENTER, B CLEAR, C-F ignored
//   armed_in   in  1 : alarm FSM is not OFF
//   arm_cmd    out 1 : pulse, request OFF -> ARMED
//   disarm_cmd out 1 : pulse, request return to OFF
//   err        out 1 : pulse, entry rejected
//   lockout    out 1 : level, high while locked out
//   digit_cnt  out 3 : digits buffered (0-4)
//   state_o    out 2 : current state encoding
// ---------------------------------------------------------------------------
module alarm_keypad_ctrl
   import alarm_pkg::*;
#(
   parameter logic [15:0] PIN            = 16'h1234,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          MAX_FAIL       = 3,
   parameter int          LOCKOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       armed_in,
   output logic       arm_cmd,
   output logic       disarm_cmd,
   output logic       err,
   output logic       lockout,
   output logic [2:0] digit_cnt,
   output logic [1:0] state_o
);

   localparam int MAX_CYC = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
   localparam int TW      = $clog2(MAX_CYC + 1);
   localparam int FW      = $clog2(MAX_FAIL + 1);

   // Timers fire one edge after reaching zero, so they are loaded with N-1.
   localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] LK_LOAD = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAIL);

   kp_state_t     state;
   logic [15:0]   entry_buf;
   logic          overflow;
   logic [FW-1:0] fail_cnt;

   logic          key_digit;
   logic          pin_match;
   logic [FW-1:0] fail_next;
   logic          to_load;
   logic          to_expired;
   logic          lk_load;
   logic          lk_expired;

   // Decode of the current cycle: whether this key is a digit, whether the
   // buffered entry matches, and when each timer must be (re)started. The
   // timeout timer restarts on every digit taken in IDLE or ENTRY, but not
   // on the edge where it expires, because that key is discarded.
   always_comb begin
      key_digit = key_valid && is_digit(key_code);
      pin_match = (digit_cnt == 3'd4) && !overflow && (entry_buf == PIN);
      fail_next = fail_cnt + FW'(1);
      to_load   = key_digit &&
                  ((state == KP_IDLE) || ((state == KP_ENTRY) && !to_expired));
      lk_load   = (state == KP_CHECK) && !pin_match && (fail_next == FAIL_LIMIT);
   end

   alarm_timer #(.W(TW)) u_timeout_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (to_load),
      .value   (TO_LOAD),
      .expired (to_expired)
   );

   alarm_timer #(.W(TW)) u_lockout_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (lk_load),
      .value   (LK_LOAD),
      .expired (lk_expired)
   );

   // Main keypad state machine. The command pulses default low every cycle
   // and are only raised from CHECK, which lasts a single cycle and is always
   // followed by IDLE or LOCKOUT, so they can never overlap or repeat.
   // Digits are written by position (first digit into entry_buf[15:12]) so
   // a complete entry reads d1 d2 d3 d4 from MSB to LSB, lining up with PIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= KP_IDLE;
         entry_buf  <= '0;
         digit_cnt  <= '0;
         overflow   <= 1'b0;
         fail_cnt   <= '0;
         arm_cmd    <= 1'b0;
         disarm_cmd <= 1'b0;
         err        <= 1'b0;
         lockout    <= 1'b0;
      end else begin
         arm_cmd    <= 1'b0;
         disarm_cmd <= 1'b0;
         err        <= 1'b0;
         case (state)
            KP_IDLE: begin
               if (key_digit) begin
                  entry_buf <= {key_code, 12'h000};
                  digit_cnt <= 3'd1;
                  overflow  <= 1'b0;
                  state     <= KP_ENTRY;
               end
            end
            KP_ENTRY: begin
               if (to_expired) begin
                  entry_buf <= '0;
                  digit_cnt <= '0;
                  overflow  <= 1'b0;
                  state     <= KP_IDLE;
               end else if (key_digit) begin
                  if (digit_cnt < 3'd4) begin
                     case (digit_cnt)
                        3'd1:    entry_buf[11:8] <= key_code;
                        3'd2:    entry_buf[7:4]  <= key_code;
                        default: entry_buf[3:0]  <= key_code;
                     endcase
                     digit_cnt <= digit_cnt + 3'd1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end else if (key_valid && (key_code == KEY_CLEAR)) begin
                  entry_buf <= '0;
                  digit_cnt <= '0;
                  overflow  <= 1'b0;
                  state     <= KP_IDLE;
               end else if (key_valid && (key_code == KEY_ENTER)) begin
                  state <= KP_CHECK;
               end
            end
            KP_CHECK: begin
               if (pin_match) begin
                  if (armed_in) begin
                     disarm_cmd <= 1'b1;
                  end else begin
                     arm_cmd <= 1'b1;
                  end
                  fail_cnt <= '0;
                  state    <= KP_IDLE;
               end else begin
                  err      <= 1'b1;
                  fail_cnt <= fail_next;
                  if (fail_next == FAIL_LIMIT) begin
                     lockout <= 1'b1;
                     state   <= KP_LOCKOUT;
                  end else begin
                     state <= KP_IDLE;
                  end
               end
               entry_buf <= '0;
               digit_cnt <= '0;
               overflow  <= 1'b0;
            end
            KP_LOCKOUT: begin
               if (lk_expired) begin
                  lockout  <= 1'b0;
                  fail_cnt <= '0;
                  state    <= KP_IDLE;
               end
            end
            default: state <= KP_IDLE;
         endcase
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_alarm_keypad_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alarm_keypad_ctrl
// Directed bench for alarm_keypad_ctrl with default parameters. Expected
// command/err pulses (kind and cycle) are queued when ENTER is driven and
// matched against pulses captured by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_alarm_keypad_ctrl;
   import alarm_pkg::*;

   typedef struct {
      logic [2:0] kind;
      int         cyc;
   } pulse_t;

   localparam logic [2:0] P_NONE   = 3'b000;
   localparam logic [2:0] P_ARM    = 3'b001;
   localparam logic [2:0] P_DISARM = 3'b010;
   localparam logic [2:0] P_ERR    = 3'b100;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [3:0] key_code;
   logic       armed_in;
   logic       arm_cmd;
   logic       disarm_cmd;
   logic       err;
   logic       lockout;
   logic [2:0] digit_cnt;
   logic [1:0] state_o;

   int     cyc = 0;
   int     keyEdge = 0;
   int     lockEdge = 0;
   int     testCount = 0;
   int     failCount = 0;
   pulse_t expQ[$];
   pulse_t obsQ[$];

   alarm_keypad_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .armed_in   (armed_in),
      .arm_cmd    (arm_cmd),
      .disarm_cmd (disarm_cmd),
      .err        (err),
      .lockout    (lockout),
      .digit_cnt  (digit_cnt),
      .state_o    (state_o)
   );

   // 10-unit clock with an edge counter used to time-stamp pulses.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Capture every command/err pulse with the cycle it was seen in.
   always @(negedge clk) begin
      pulse_t p;
      if (arm_cmd || disarm_cmd || err) begin
         p.kind = {err, disarm_cmd, arm_cmd};
         p.cyc  = cyc;
         obsQ.push_back(p);
      end
   end

   // Drive one key for exactly one cycle; called #1 after a rising edge.
   task automatic applyStimulus(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      @(posedge clk);
      #1;
      keyEdge   = cyc;
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   task automatic checkLevel(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Queue the pulse that the ENTER just sampled should produce.
   task automatic expectPulse(input logic [2:0] kind);
      pulse_t e;
      e.kind = kind;
      e.cyc  = keyEdge + 1;
      expQ.push_back(e);
   endtask

   // Let the pulse appear, then pop one expectation and one observation.
   task automatic checkOutput(input string tag);
      pulse_t e;
      pulse_t o;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      if (expQ.size() > 0) e = expQ.pop_front();
      else begin
         e.kind = P_NONE;
         e.cyc  = 0;
      end
      if (obsQ.size() > 0) o = obsQ.pop_front();
      else begin
         o.kind = P_NONE;
         o.cyc  = 0;
      end
      checkLevel({tag, "_kind"}, 32'(o.kind), 32'(e.kind));
      if (e.kind != P_NONE) checkLevel({tag, "_cycle"}, o.cyc, e.cyc);
      checkLevel({tag, "_extra"}, obsQ.size(), 0);
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic enter1234(input logic [2:0] kind, input string tag);
      applyStimulus(4'd1);
      applyStimulus(4'd2);
      applyStimulus(4'd3);
      applyStimulus(4'd4);
      applyStimulus(KEY_ENTER);
      expectPulse(kind);
      checkOutput(tag);
   endtask

   initial begin
      rst       = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'h0;
      armed_in  = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      checkLevel("rst_state", state_o, 0);
      checkLevel("rst_digits", digit_cnt, 0);
      checkLevel("rst_pulses", {arm_cmd, disarm_cmd, err}, 0);
      checkLevel("rst_lockout", lockout, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Arm with the correct PIN
      applyStimulus(4'd1);
      checkLevel("arm_cnt1", digit_cnt, 1);
      checkLevel("arm_entry", state_o, 1);
      applyStimulus(4'd2);
      applyStimulus(4'd3);
      applyStimulus(4'd4);
      checkLevel("arm_cnt4", digit_cnt, 4);
      applyStimulus(KEY_ENTER);
      expectPulse(P_ARM);
      checkLevel("arm_check", state_o, 2);
      checkOutput("arm");
      checkLevel("arm_cnt_after", digit_cnt, 0);
      checkLevel("arm_idle", state_o, 0);

      // Disarm while the alarm is armed
      armed_in = 1'b1;
      enter1234(P_DISARM, "disarm");
      armed_in = 1'b0;

      // Short entry
      applyStimulus(4'd1);
      applyStimulus(4'd2);
      applyStimulus(4'd3);
      applyStimulus(KEY_ENTER);
      expectPulse(P_ERR);
      checkOutput("bad_short");
      checkLevel("fail_cnt1", dut.fail_cnt, 1);

      // Overflowing entry
      applyStimulus(4'd1);
      applyStimulus(4'd2);
      applyStimulus(4'd3);
      applyStimulus(4'd4);
      applyStimulus(4'd5);
      checkLevel("ovf_cnt", digit_cnt, 4);
      applyStimulus(KEY_ENTER);
      expectPulse(P_ERR);
      checkOutput("bad_ovf");
      checkLevel("fail_cnt2", dut.fail_cnt, 2);

      // Third wrong entry triggers lockout
      applyStimulus(4'd1);
      applyStimulus(4'd2);
      applyStimulus(4'd3);
      applyStimulus(KEY_ENTER);
      lockEdge = keyEdge;
      expectPulse(P_ERR);
      checkLevel("lock_pre", lockout, 0);
      @(posedge clk);
      #1;
      checkLevel("lock_rise", lockout, 1);
      checkLevel("lock_state", state_o, 3);
      checkOutput("bad_lock");

      // Correct PIN during lockout is ignored
      enter1234(P_NONE, "lock_ignored");
      checkLevel("lock_digits", digit_cnt, 0);
      waitUntil(lockEdge + 5000);
      checkLevel("lock_last", lockout, 1);
      @(posedge clk);
      #1;
      checkLevel("lock_fall", lockout, 0);
      checkLevel("lock_idle", state_o, 0);
      checkLevel("lock_fail_clr", dut.fail_cnt, 0);
      enter1234(P_ARM, "after_lock");

      // CLEAR abandons an entry without counting a failure
      applyStimulus(4'd9);
      applyStimulus(4'd9);
      applyStimulus(KEY_CLEAR);
      checkLevel("clr_cnt", digit_cnt, 0);
      checkLevel("clr_idle", state_o, 0);
      enter1234(P_ARM, "clear_arm");
      checkLevel("clr_fail", dut.fail_cnt, 0);

      // Inter-key timeout
      applyStimulus(4'd1);
      applyStimulus(4'd2);
      waitUntil(keyEdge + 999);
      checkLevel("to_before", state_o, 1);
      checkLevel("to_cnt_before", digit_cnt, 2);
      @(posedge clk);
      #1;
      checkLevel("to_idle", state_o, 0);
      checkLevel("to_cnt", digit_cnt, 0);
      @(posedge clk);
      #1;
      applyStimulus(4'd3);
      applyStimulus(4'd4);
      checkLevel("to_cnt2", digit_cnt, 2);
      applyStimulus(KEY_ENTER);
      expectPulse(P_ERR);
      checkOutput("to_err");
      checkLevel("to_fail", dut.fail_cnt, 1);

      // Reset during the CHECK cycle drops the pulse
      applyStimulus(4'd1);
      applyStimulus(4'd2);
      applyStimulus(4'd3);
      applyStimulus(4'd4);
      applyStimulus(KEY_ENTER);
      expectPulse(P_NONE);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkLevel("rm_state", state_o, 0);
      checkLevel("rm_pulses", {arm_cmd, disarm_cmd, err}, 0);
      checkLevel("rm_outputs", {lockout, digit_cnt}, 0);
      checkLevel("rm_fail", dut.fail_cnt, 0);
      checkOutput("rst_mid");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
